// File: rtl/switch_debouncer_pkg.sv
// Shared types and constants for the switch debouncer.
// State encoding, default timing and a width helper.
package switch_pkg;

  typedef enum logic {
    IDLE,
    CONFIRM
  } db_state_t;

  localparam int DEF_TICK_DIV     = 8192;
  localparam int DEF_STABLE_TICKS = 4;

  // Bits needed to hold values 0..value-1, at least one.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// Single-bit debounce FSM driven by the shared sample tick.
// Accepts a new level after STABLE_TICKS differing samples.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sync_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW   = clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS);

  db_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          differ;

  assign cnt_inc = cnt + CW'(1);
  assign differ  = sync_in ^ level;

  // Confirm state machine; edge pulses last one cycle after a commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      level <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (!differ) begin
              cnt <= '0;
            end else if (STABLE_TICKS == 1) begin
              level <= sync_in;
              rise  <= sync_in;
              fall  <= ~sync_in;
              cnt   <= '0;
            end else begin
              cnt   <= CW'(1);
              state <= CONFIRM;
            end
          end
          CONFIRM: begin
            if (!differ) begin
              cnt   <= '0;
              state <= IDLE;
            end else if (cnt_inc == LAST) begin
              level <= sync_in;
              rise  <= sync_in;
              fall  <= ~sync_in;
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Switch/button front end: synchronise, prescale, debounce.
// Emits clean levels plus one-cycle rise/fall pulses.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int                  N_INPUTS     = 8,
  parameter int                  TICK_DIV     = DEF_TICK_DIV,
  parameter int                  STABLE_TICKS = DEF_STABLE_TICKS,
  parameter logic [N_INPUTS-1:0] RESET_LEVEL  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] raw_in,
  output logic [N_INPUTS-1:0] level,
  output logic [N_INPUTS-1:0] rise,
  output logic [N_INPUTS-1:0] fall,
  output logic                any_change,
  output logic                tick
);

  localparam int            PW      = clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  logic [N_INPUTS-1:0] sync_d;
  logic [N_INPUTS-1:0] sync_q;
  logic [PW-1:0]       ps_cnt;

  // Two-flop synchroniser on every raw input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_d <= RESET_LEVEL;
      sync_q <= RESET_LEVEL;
    end else begin
      sync_d <= raw_in;
      sync_q <= sync_d;
    end
  end

  // Shared prescaler; tick marks its last count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps_cnt <= '0;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PW'(1);
    end
  end

  assign tick = (ps_cnt == PS_LAST);

  for (genvar i = 0; i < N_INPUTS; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_LEVEL (RESET_LEVEL[i])
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .sync_in(sync_q[i]),
      .level  (level[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign any_change = |(rise | fall);

endmodule
